// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: priority state, request bundle, port count.
package dmem_arb_pkg;
   localparam int NUM_PORTS = 2;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 16;

   typedef enum logic {PRIO_P0, PRIO_P1} arb_prio_t;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the memory pins seen by dmem_arbiter.
interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) ();
   logic                  req0_valid, req0_we, req0_ready;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic                  req1_valid, req1_we, req1_ready;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic                  rsp0_valid, rsp0_err;
   logic [DATA_WIDTH-1:0] rsp0_rdata;
   logic                  rsp1_valid, rsp1_err;
   logic [DATA_WIDTH-1:0] rsp1_rdata;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_d;
   logic [DATA_WIDTH-1:0] mem_q;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata,
      output mem_we, mem_addr, mem_d,
      input  mem_q
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata,
      input  mem_we, mem_addr, mem_d,
      output mem_q
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Fixed-priority two-port arbiter for the single-port data memory, with a
// starvation counter that hands port 1 priority after STARVE_LIMIT denied cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_W,
   parameter int ADDR_WIDTH   = ADDR_W,
   parameter int DEPTH        = 1024,
   parameter int STARVE_LIMIT = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);
   localparam logic [3:0]        LIMIT   = 4'(STARVE_LIMIT);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

   req_t                   req [NUM_PORTS];
   logic [NUM_PORTS-1:0]   gnt, oor;
   arb_prio_t              prio, prio_nxt;
   logic [3:0]             wait_cnt, cnt_nxt;
   logic                   rsp_v   [NUM_PORTS];
   logic                   rsp_e   [NUM_PORTS];
   logic [DATA_WIDTH-1:0]  rsp_d   [NUM_PORTS];

   assign req[0] = '{valid: bus.req0_valid, we: bus.req0_we,
                     addr: ADDR_W'(bus.req0_addr), wdata: DATA_W'(bus.req0_wdata)};
   assign req[1] = '{valid: bus.req1_valid, we: bus.req1_we,
                     addr: ADDR_W'(bus.req1_addr), wdata: DATA_W'(bus.req1_wdata)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio     <= PRIO_P0;
         wait_cnt <= '0;
      end else begin
         prio     <= prio_nxt;
         wait_cnt <= cnt_nxt;
      end
   end

   // Switching on the count's next value lets port 1 win on cycle STARVE_LIMIT+1.
   always_comb begin
      cnt_nxt  = wait_cnt;
      prio_nxt = prio;
      if (!req[1].valid || gnt[1])
         cnt_nxt = '0;
      else if (wait_cnt < LIMIT)
         cnt_nxt = wait_cnt + 4'd1;
      case (prio)
         PRIO_P0: if (cnt_nxt == LIMIT) prio_nxt = PRIO_P1;
         PRIO_P1: if (gnt[1])           prio_nxt = PRIO_P0;
         default:                       prio_nxt = PRIO_P0;
      endcase
   end

   always_comb begin
      gnt          = '0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_d    = '0;
      if (rst_n) begin
         case (prio)
            PRIO_P1: begin
               gnt[1] = req[1].valid;
               gnt[0] = req[0].valid & ~req[1].valid;
            end
            default: begin
               gnt[0] = req[0].valid;
               gnt[1] = req[1].valid & ~req[0].valid;
            end
         endcase
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt[p]) begin
            bus.mem_we   = req[p].we & ~oor[p];
            bus.mem_addr = ADDR_WIDTH'(req[p].addr);
            bus.mem_d    = DATA_WIDTH'(req[p].wdata);
         end
      end
   end

   assign bus.req0_ready = gnt[0];
   assign bus.req1_ready = gnt[1];

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
      assign oor[p] = {1'b0, req[p].addr} >= DEPTH_L;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rsp_v[p] <= 1'b0;
            rsp_e[p] <= 1'b0;
            rsp_d[p] <= '0;
         end else begin
            rsp_v[p] <= gnt[p] & ~req[p].we;
            rsp_e[p] <= gnt[p] & oor[p];
            rsp_d[p] <= (gnt[p] & ~req[p].we & ~oor[p]) ? bus.mem_q : '0;
         end
      end
   end

   assign bus.rsp0_valid = rsp_v[0];
   assign bus.rsp0_err   = rsp_e[0];
   assign bus.rsp0_rdata = rsp_d[0];
   assign bus.rsp1_valid = rsp_v[1];
   assign bus.rsp1_err   = rsp_e[1];
   assign bus.rsp1_rdata = rsp_d[1];
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the pipeline MEM stage (port 0) and the program/data loader (port 1). Port 0 has fixed priority. A starvation counter guarantees port 1 a grant within a bounded number of cycles. Read data returns through a registered response stage, one cycle after grant. The block sits between the MEM stage / loader and the memory's WE/D/ADDR/Q pins; memory read is combinational.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 16, word address width (matches memory ADDR)
- DEPTH, 1024, implemented memory words; addresses ≥ DEPTH are out of range
- STARVE_LIMIT, 3, consecutive denied cycles of port 1 before it is forced priority (1..15)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request from port N (N = 0, 1)
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_WIDTH  word address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_ready  out  1  grant; the request is accepted this cycle
- rspN_valid  out  1  read data valid (one-cycle pulse)
- rspN_rdata  out  DATA_WIDTH  read data
- rspN_err  out  1  with rspN_valid: address was out of range
- mem_we  out  1  to memory WE
- mem_addr  out  ADDR_WIDTH  to memory ADDR
- mem_d  out  DATA_WIDTH  to memory D
- mem_q  in  DATA_WIDTH  from memory Q (combinational read)

## Operation
- Handshake: valid/ready. Once reqN_valid is asserted, the requester holds it and all request fields stable until reqN_ready is high. A transfer occurs on a rising edge with valid & ready.
- FSM state `prio`, two values:
  - PRIO_P0: grant port 0 if req0_valid, else port 1 if req1_valid.
  - PRIO_P1: grant port 1 if req1_valid, else port 0.
- Transitions:
  - PRIO_P0 → PRIO_P1 when `wait_cnt` reaches STARVE_LIMIT.
  - PRIO_P1 → PRIO_P0 on the cycle port 1 is granted.
- `wait_cnt` (4 bits):
  - Increments each cycle req1_valid is high and port 1 is not granted.
  - Clears when port 1 is granted or req1_valid is low.
  - Saturates at STARVE_LIMIT.
- At most one ready per cycle. ready is combinational from valid and `prio`.
- Memory drive is combinational from the granted port (mux). With no grant: mem_we = 0, mem_addr = 0, mem_d = 0.
- Out-of-range access (addr ≥ DEPTH) is still granted:
  - Write: mem_we is forced to 0.
  - Read: rdata = 0 and rspN_err = 1.
- Read accepted: rspN_valid = 1 and rspN_rdata = mem_q (or 0 if out of range) on the next cycle, for exactly one cycle.
- Write accepted: no response. rspN_err pulses one cycle only for an out-of-range write.

## Timing
- Grant latency: 0 cycles if the port wins; port 1 worst case STARVE_LIMIT + 1 cycles under continuous port 0 traffic.
- Read latency: 1 cycle from accept edge to rsp valid.
- Back-to-back reads on the same port give a response every cycle.
- Reset values: prio = PRIO_P0, wait_cnt = 0, rspN_valid = 0, rspN_rdata = 0, rspN_err = 0.
- Reset has effect immediately on assertion. While rst_n = 0, all ready = 0 and mem_we = 0.
- Reset asserted mid-transaction drops any pending response; no retry is generated.
- Simultaneous valid on both ports with wait_cnt < STARVE_LIMIT: port 0 wins.
- Write then read of the same address by different ports in consecutive cycles: the read observes the new data.

## Structure
- Package dmem_arb_pkg:
  - arb_prio_t enum {PRIO_P0, PRIO_P1}
  - req_t struct {valid, we, addr, wdata}
  - constant NUM_PORTS = 2
- Single module. Response registers are generated per port.
- No sub-module is required; the starvation counter stays inline.

## Test plan
- Reset release, both valid low → mem_we = 0, all ready = 0, rsp outputs 0.
- Port 0 write 0x0000_00AA @ 5, then port 0 read @ 5 → rsp0_valid one cycle after the read grant, rsp0_rdata = 0xAA.
- req0 and req1 held valid continuously, STARVE_LIMIT = 3 → port 1 granted on cycle 4. Pattern repeats P0,P0,P0,P1,… with no cycle of dual grant.
- Port 1 read @ 0x0400 → granted, rsp1_valid = 1, rsp1_err = 1, rdata = 0. Port 1 write @ 0x0400 → mem_we stays 0, rsp1_err pulses.
- Port 1 write 0x1234 @ 7 then port 0 read @ 7 next cycle → rsp0_rdata = 0x1234.
- rst_n pulsed low the cycle after a port 0 read grant → rsp0_valid never asserts, prio = PRIO_P0, wait_cnt = 0.
